// File: rtl/bsg_parallel_in_serial_out_passthrough_rr_if.sv
// Link bundle for the round-robin passthrough PISO.
// The wide side carries per-channel flits; the serial side carries one beat at a time.
interface bsg_parallel_in_serial_out_passthrough_rr_if #(
  parameter int unsigned width_p = 2,
  parameter int unsigned els_p   = 4,
  parameter int unsigned chans_p = 2
);
  localparam int unsigned lg_els_lp   = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned id_width_lp = (chans_p > 1) ? $clog2(chans_p) : 1;

  logic [chans_p*els_p*width_p-1:0] wide_data;
  logic [chans_p*lg_els_lp-1:0]     wide_len;
  logic [chans_p-1:0]               wide_v;
  logic [chans_p-1:0]               wide_yumi;
  logic [width_p-1:0]               ser_data;
  logic [id_width_lp-1:0]           ser_id;
  logic                             ser_last;
  logic                             ser_v;
  logic                             ser_ready_and;

  // slave: the converter itself; master: producers plus the downstream consumer
  modport slave (
    input  wide_data, wide_len, wide_v, ser_ready_and,
    output wide_yumi, ser_data, ser_id, ser_last, ser_v
  );

  modport master (
    output wide_data, wide_len, wide_v, ser_ready_and,
    input  wide_yumi, ser_data, ser_id, ser_last, ser_v
  );
endinterface

// File: rtl/bsg_parallel_in_serial_out_passthrough_rr.sv
// Zero-storage multi-channel PISO: round-robin picks a channel per flit, then streams
// its beats LSB-first straight from the producer's held inputs onto the serial link.
module bsg_parallel_in_serial_out_passthrough_rr #(
  parameter int unsigned width_p = 2,
  parameter int unsigned els_p   = 4,
  parameter int unsigned chans_p = 2
) (
  input  logic clk,
  input  logic reset,
  bsg_parallel_in_serial_out_passthrough_rr_if.slave link_io
);
  localparam int unsigned lg_els_lp   = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned id_width_lp = (chans_p > 1) ? $clog2(chans_p) : 1;
  localparam logic [id_width_lp-1:0] LastId = id_width_lp'(chans_p - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                 state_q;
  logic [lg_els_lp-1:0]   cnt_q;
  logic [id_width_lp-1:0] rr_q;
  logic [id_width_lp-1:0] lock_q;

  logic                   busy;
  logic                   any_v;
  logic [id_width_lp-1:0] grant;
  logic [id_width_lp-1:0] sel_id;
  logic [id_width_lp-1:0] next_id;
  logic [lg_els_lp-1:0]   sel_beat;
  logic [lg_els_lp-1:0]   sel_len;
  logic                   sel_v;
  logic                   last;
  logic                   hs;

  // First requester at or after rr_q, wrapping around.
  always_comb begin
    grant = '0;
    any_v = 1'b0;
    for (int i = 0; i < int'(chans_p); i++) begin
      if (!any_v && link_io.wide_v[(int'(rr_q) + i) % int'(chans_p)]) begin
        any_v = 1'b1;
        grant = id_width_lp'((int'(rr_q) + i) % int'(chans_p));
      end
    end
  end

  assign busy     = (state_q == StBusy);
  assign sel_id   = busy ? lock_q : grant;
  assign sel_beat = busy ? cnt_q : '0;
  assign sel_len  = link_io.wide_len[int'(sel_id)*lg_els_lp +: lg_els_lp];
  assign sel_v    = busy ? link_io.wide_v[sel_id] : any_v;
  assign last     = (sel_beat == sel_len);
  assign next_id  = (sel_id == LastId) ? '0 : sel_id + id_width_lp'(1);

  // Reset gates v_o combinationally so an aborted flit stops on the spot.
  assign link_io.ser_v    = reset & sel_v;
  assign link_io.ser_data =
    link_io.wide_data[(int'(sel_id)*els_p + int'(sel_beat))*width_p +: width_p];
  assign link_io.ser_id   = sel_id;
  assign link_io.ser_last = last;
  assign hs               = link_io.ser_v & link_io.ser_ready_and;

  always_comb begin
    link_io.wide_yumi = '0;
    if (hs && last) link_io.wide_yumi[sel_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rr_q    <= '0;
      lock_q  <= '0;
    end else if (hs) begin
      case (state_q)
        StIdle: begin
          if (last) begin
            rr_q <= next_id;
          end else begin
            lock_q  <= grant;
            cnt_q   <= lg_els_lp'(1);
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (last) begin
            cnt_q   <= '0;
            rr_q    <= next_id;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + lg_els_lp'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
